// File: rtl/r200_ifetch_if.sv
// =============================================================================
// r200_ifetch_if : instruction-memory and decode-side signals of the fetch stage
// Revision: 1.0
// =============================================================================
`default_nettype none

interface r200_ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] instrn;
  logic [31:0] pc_addrout;
  logic [31:0] pcp4;
  logic        redirect;
  logic [31:0] pc_brtarg;

  modport master (
    output imem_req, imem_addr, id_valid, instrn, pc_addrout, pcp4,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect, pc_brtarg
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, instrn, pc_addrout, pcp4,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect, pc_brtarg
  );
endinterface

`default_nettype wire

// File: rtl/r200_ifetch.sv
// =============================================================================
// r200_ifetch : in-order instruction fetch with credit-limited prefetch FIFO
// Revision: 1.0
// =============================================================================
`default_nettype none

module r200_ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  r200_ifetch_if.master    bus
);

  localparam int unsigned      PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_X  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      NOP      = 32'h0000_0013;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      fifo_pc_q  [FIFO_DEPTH];
  logic [31:0]      fifo_pc_d  [FIFO_DEPTH];
  logic [31:0]      fifo_ins_q [FIFO_DEPTH];
  logic [31:0]      fifo_ins_d [FIFO_DEPTH];

  logic        fifo_empty, rsp_keep, head_valid, credit_ok, fetch_req;
  logic        grant, pop, pop_store, push;
  logic [31:0] head_pc, head_ins;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // An empty FIFO passes a kept response straight through so steady state is one word per cycle.
  always_comb begin
    fifo_empty = (count_q == '0);
    rsp_keep   = bus.imem_rvalid && (drop_cnt_q == '0);
    head_valid = !fifo_empty || rsp_keep;
    if (!fifo_empty) begin
      head_pc  = fifo_pc_q[rd_ptr_q];
      head_ins = fifo_ins_q[rd_ptr_q];
    end else begin
      head_pc  = resp_pc_q;
      head_ins = rsp_keep ? bus.imem_rdata : NOP;
    end
    credit_ok = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_X;
    fetch_req = !bus.redirect && credit_ok;
    grant     = fetch_req && bus.imem_gnt;
    pop       = head_valid && bus.id_ready && !bus.redirect;
    pop_store = pop && !fifo_empty;
    push      = rsp_keep && !bus.redirect && !(fifo_empty && pop);
  end

  assign bus.imem_req   = fetch_req;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.id_valid   = head_valid;
  assign bus.instrn     = head_ins;
  assign bus.pc_addrout = head_pc;
  assign bus.pcp4       = head_pc + 32'd4;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_ins_d    = fifo_ins_q;
    if (bus.redirect) begin
      // Everything still in flight, including a response landing now, belongs to the old path.
      fetch_pc_d    = bus.pc_brtarg & 32'hFFFF_FFFC;
      resp_pc_d     = bus.pc_brtarg & 32'hFFFF_FFFC;
      outstanding_d = outstanding_q - CNT_W'(bus.imem_rvalid);
      drop_cnt_d    = outstanding_q - CNT_W'(bus.imem_rvalid);
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
    end else begin
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(bus.imem_rvalid);
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (bus.imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      if (rsp_keep) resp_pc_d = resp_pc_q + 32'd4;
      if (push) begin
        fifo_pc_d[wr_ptr_q]  = resp_pc_q;
        fifo_ins_d[wr_ptr_q] = bus.imem_rdata;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
      end
      if (pop_store) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_store);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fifo_pc_q     <= '{default: '0};
      fifo_ins_q    <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_ins_q    <= fifo_ins_d;
    end
  end

  a_no_push_on_full : assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == FULL_CNT)));

endmodule

`default_nettype wire

// File: tb/tb_r200_ifetch.sv
// =============================================================================
// tb_r200_ifetch : randomized bench for r200_ifetch with a queue-based reference model
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_r200_ifetch;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  r200_ifetch_if bus();

  r200_ifetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1, redir_pct = 0;
  logic        force_redir = 1'b0;
  logic [31:0] force_tgt   = 32'h0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due;

  logic [31:0] m_fetch_pc, m_resp_pc;
  int          m_out, m_drop;
  logic [31:0] m_fpc[$], m_fins[$];

  int          pops;
  logic [31:0] popped[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'hA000_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fetch_pc = 32'h0; m_resp_pc = 32'h0; m_out = 0; m_drop = 0;
    m_fpc.delete(); m_fins.delete();
    pend_addr.delete(); pend_due.delete(); last_due = -1;
  endtask

  task automatic drive_inputs();
    bus.imem_gnt = ($urandom_range(99) < gnt_pct);
    bus.id_ready = ($urandom_range(99) < rdy_pct);
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    if (force_redir) begin
      bus.redirect = 1'b1; bus.pc_brtarg = force_tgt;
    end else if ($urandom_range(99) < redir_pct) begin
      bus.redirect = 1'b1;
      case ($urandom_range(2))
        0:       bus.pc_brtarg = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        1:       bus.pc_brtarg = 32'($urandom_range(255));
        default: bus.pc_brtarg = $urandom;
      endcase
    end else begin
      bus.redirect = 1'b0; bus.pc_brtarg = $urandom;
    end
  endtask

  // Outputs are derived from the queue model and current inputs, then the model advances one edge.
  task automatic check_update();
    logic        keep, exp_valid, exp_req, grant;
    logic [31:0] exp_pc, exp_ins;
    int          n, lat, due;
    n         = m_fpc.size();
    keep      = bus.imem_rvalid && (m_drop == 0);
    exp_valid = (n > 0) || keep;
    exp_pc    = (n > 0) ? m_fpc[0] : m_resp_pc;
    exp_ins   = (n > 0) ? m_fins[0] : (keep ? bus.imem_rdata : 32'h0000_0013);
    exp_req   = !bus.redirect && (m_out + n < DEPTH);
    chk("imem_req",   {31'b0, bus.imem_req}, {31'b0, exp_req});
    chk("imem_addr",  bus.imem_addr, m_fetch_pc);
    chk("id_valid",   {31'b0, bus.id_valid}, {31'b0, exp_valid});
    chk("instrn",     bus.instrn, exp_ins);
    chk("pc_addrout", bus.pc_addrout, exp_pc);
    chk("pcp4",       bus.pcp4, exp_pc + 32'd4);
    if (bus.id_valid && bus.id_ready && !bus.redirect) begin
      chk("stream_word", bus.instrn, mem_word(bus.pc_addrout));
      pops++;
      popped.push_back(bus.pc_addrout);
    end
    if (bus.imem_req && bus.imem_gnt) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(bus.imem_addr);
      pend_due.push_back(due);
    end
    if (bus.redirect) begin
      m_out   = m_out - (bus.imem_rvalid ? 1 : 0);
      m_drop  = m_out;
      m_fpc.delete(); m_fins.delete();
      m_fetch_pc = bus.pc_brtarg & 32'hFFFF_FFFC;
      m_resp_pc  = bus.pc_brtarg & 32'hFFFF_FFFC;
    end else begin
      grant = exp_req && bus.imem_gnt;
      if (bus.imem_rvalid) begin
        m_out--;
        if (m_drop > 0) m_drop--;
        else begin
          m_fpc.push_back(m_resp_pc); m_fins.push_back(bus.imem_rdata);
          m_resp_pc = m_resp_pc + 32'd4;
        end
      end
      if (exp_valid && bus.id_ready) begin
        void'(m_fpc.pop_front()); void'(m_fins.pop_front());
      end
      if (grant) begin
        m_fetch_pc = m_fetch_pc + 32'd4;
        m_out++;
      end
    end
    if (m_fpc.size() > DEPTH) chk("model_overflow", 32'(m_fpc.size()), DEPTH);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    drive_inputs();
    @(negedge clk);
    check_update();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.id_ready = 1'b0; bus.redirect = 1'b0; bus.pc_brtarg = 32'h0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_req",    {31'b0, bus.imem_req}, 32'h1);
      chk("rst_addr",   bus.imem_addr, 32'h0);
      chk("rst_valid",  {31'b0, bus.id_valid}, 32'h0);
      chk("rst_instrn", bus.instrn, 32'h0000_0013);
      chk("rst_pc",     bus.pc_addrout, 32'h0);
      chk("rst_pcp4",   bus.pcp4, 32'h4);
    end
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.id_valid) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) chk(name, 32'h0, 32'h1);
  endtask

  initial begin
    logic ok;
    int   base;
    // Reset release with no grants: request held at RESET_PC.
    gnt_pct = 0; rdy_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;
    do_reset(3);
    for (int i = 0; i < 4; i++) step();
    chk("t1_addr_held", bus.imem_addr, 32'h0);
    chk("t1_req_held",  {31'b0, bus.imem_req}, 32'h1);

    // Streaming at one instruction per cycle.
    gnt_pct = 100;
    do_reset(2);
    step(); step();
    chk("t2_first_valid", {31'b0, bus.id_valid}, 32'h1);
    chk("t2_first_pc",    bus.pc_addrout, 32'h0);
    step(); step();
    pops = 0;
    for (int i = 0; i < 20; i++) step();
    chk("t2_throughput", 32'(pops), 32'd20);

    // Decode stall fills the FIFO and stops requests.
    rdy_pct = 0;
    do_reset(2);
    for (int i = 0; i < 10; i++) step();
    chk("t3_valid", {31'b0, bus.id_valid}, 32'h1);
    chk("t3_pc",    bus.pc_addrout, 32'h0);
    chk("t3_req",   {31'b0, bus.imem_req}, 32'h0);
    rdy_pct = 100;
    popped.delete();
    for (int i = 0; i < 20 && popped.size() < 3; i++) step();
    if (popped.size() < 3) chk("t3_pops_timeout", 32'(popped.size()), 32'd3);
    else begin
      chk("t3_pop0", popped[0], 32'h0);
      chk("t3_pop1", popped[1], 32'h4);
      chk("t3_pop2", popped[2], 32'h8);
    end

    // Redirect with two grants in flight.
    lat_min = 3; lat_max = 3;
    do_reset(2);
    step(); step();
    force_redir = 1'b1; force_tgt = 32'h0000_0103;
    step();
    force_redir = 1'b0;
    step();
    chk("t4_addr", bus.imem_addr, 32'h0000_0100);
    wait_valid("t4_valid_timeout", ok);
    if (ok) begin
      chk("t4_pc",     bus.pc_addrout, 32'h0000_0100);
      chk("t4_pcp4",   bus.pcp4, 32'h0000_0104);
      chk("t4_instrn", bus.instrn, mem_word(32'h0000_0100));
    end

    // Redirect coinciding with pop and response.
    lat_min = 1; lat_max = 1;
    do_reset(2);
    for (int i = 0; i < 4; i++) step();
    rdy_pct = 0;
    step();
    rdy_pct = 100; force_redir = 1'b1; force_tgt = 32'h0000_0040;
    step();
    force_redir = 1'b0;
    step();
    chk("t5_empty", {31'b0, bus.id_valid}, 32'h0);
    chk("t5_addr",  bus.imem_addr, 32'h0000_0040);
    for (int i = 0; i < 6; i++) step();

    // Address wrap at the top of memory.
    do_reset(2);
    step(); step();
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFFC;
    step();
    force_redir = 1'b0;
    step();
    chk("t6_addr", bus.imem_addr, 32'hFFFF_FFFC);
    wait_valid("t6_valid_timeout", ok);
    if (ok) begin
      chk("t6_pc",   bus.pc_addrout, 32'hFFFF_FFFC);
      chk("t6_pcp4", bus.pcp4, 32'h0000_0000);
      step();
      chk("t6_wrap_pc", bus.pc_addrout, 32'h0000_0000);
    end

    // Randomized traffic with occasional mid-run resets.
    do_reset(2);
    for (int blk = 0; blk < 15; blk++) begin
      gnt_pct   = $urandom_range(100, 30);
      rdy_pct   = $urandom_range(100, 30);
      lat_max   = $urandom_range(4, 1);
      redir_pct = $urandom_range(8, 0);
      base = pops;
      for (int i = 0; i < 200; i++) step();
      if (blk % 5 == 4) do_reset(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

`default_nettype wire
